// File: rtl/tia_cx_read.sv
// TIA collision latch block: fifteen pairwise collision latches set on visible
// pixels, cleared by CXCLR, and read back two bits at a time through a
// one-cycle-latency read port.
module tia_cx_read (
  input  logic       clk,
  input  logic       r_n,
  input  logic       pix_en,
  input  logic [5:0] obj,
  input  logic       cxclr,
  input  logic       rd_req,
  input  logic [3:0] addr,
  output logic       rd_ack,
  output logic [1:0] data,
  output logic [14:0] cx
);

  // Object bit positions within obj.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int M0 = 2;
  localparam int M1 = 3;
  localparam int BL = 4;
  localparam int PF = 5;

  // Pair table indexed by cx bit; bit 14 is CXM0P D7, bit 0 is CXPPMM D6.
  localparam int PAIR_A [15] = '{M0, P0, BL, M1, M1, M0, M0, P1, P1, P0, P0, M1, M1, M0, M0};
  localparam int PAIR_B [15] = '{M1, P1, PF, BL, PF, BL, PF, BL, PF, BL, PF, P1, P0, P0, P1};

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACK         = 2'd1,
    ACK_PENDING = 2'd2
  } state_t;

  logic [14:0] cx_reg;
  logic [14:0] hit;
  logic [1:0]  data_reg;
  logic [1:0]  rd_data;
  state_t      state_reg;
  state_t      state_next;

  // One coincidence detector per object pair, qualified by the pixel strobe.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_pair
      assign hit[gi] = pix_en & obj[PAIR_A[gi]] & obj[PAIR_B[gi]];
    end
  endgenerate

  // Collision latches: reset beats clear, clear beats set, otherwise sticky OR.
  always_ff @(posedge clk) begin
    if (!r_n) begin
      cx_reg <= '0;
    end else if (cxclr) begin
      cx_reg <= '0;
    end else begin
      cx_reg <= cx_reg | hit;
    end
  end

  // Register map decode from the latch state seen at the start of the cycle.
  always_comb begin
    rd_data = 2'b00;
    case (addr)
      4'h0: rd_data = {cx_reg[14], cx_reg[13]};
      4'h1: rd_data = {cx_reg[12], cx_reg[11]};
      4'h2: rd_data = {cx_reg[10], cx_reg[9]};
      4'h3: rd_data = {cx_reg[8],  cx_reg[7]};
      4'h4: rd_data = {cx_reg[6],  cx_reg[5]};
      4'h5: rd_data = {cx_reg[4],  cx_reg[3]};
      4'h6: rd_data = {cx_reg[2],  1'b0};
      4'h7: rd_data = {cx_reg[1],  cx_reg[0]};
      default: rd_data = 2'b00;
    endcase
  end

  // Read data register: captured on a request, forced to zero otherwise so
  // the bus idles at 2'b00 whenever no acknowledge is due.
  always_ff @(posedge clk) begin
    if (!r_n) begin
      data_reg <= 2'b00;
    end else if (rd_req) begin
      data_reg <= rd_data;
    end else begin
      data_reg <= 2'b00;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!r_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM next state; a request arriving while acknowledging moves to
  // ACK_PENDING so back-to-back requests are each acknowledged in turn.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:        state_next = rd_req ? ACK : IDLE;
      ACK:         state_next = rd_req ? ACK_PENDING : IDLE;
      ACK_PENDING: state_next = rd_req ? ACK_PENDING : IDLE;
      default:     state_next = IDLE;
    endcase
  end

  assign rd_ack = (state_reg == ACK) || (state_reg == ACK_PENDING);
  assign data   = data_reg;
  assign cx     = cx_reg;

endmodule
